// File: rtl/keccak_obi_ctrl_if.sv
// OBI slave bus bundle between ext_bus and the Keccak register front end.
interface keccak_obi_ctrl_if;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned BeW   = DataW / 8;

    logic             req;
    logic             we;
    logic [BeW-1:0]   be;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [DataW-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/keccak_obi_ctrl.sv
// Memory-mapped front end for Keccak-f[1600]: 50-word state buffer, start/done
// control, status/interrupt registers, single-cycle-grant OBI slave.
module keccak_obi_ctrl #(
    parameter int unsigned STATE_WORDS = 50
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    keccak_obi_ctrl_if.slave             slave_bus,
    output logic                         core_start_o,
    output logic [32*STATE_WORDS-1:0]    core_state_o,
    input  logic                         core_done_i,
    input  logic [32*STATE_WORDS-1:0]    core_state_i,
    output logic                         intr_o
);
    localparam int unsigned WordW     = 32;
    localparam int unsigned ByteW     = 8;
    localparam int unsigned BeW       = WordW / ByteW;
    localparam int unsigned IdxW      = 6;
    localparam int unsigned CtrlIdx   = 50;
    localparam int unsigned StatusIdx = 51;
    localparam int unsigned IntrEnIdx = 52;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                              state_q;
    logic [STATE_WORDS-1:0][WordW-1:0]   buf_q;
    logic [STATE_WORDS-1:0][WordW-1:0]   core_words_c;
    logic                                done_q, done_d;
    logic                                intr_en_q, intr_en_d;
    logic                                intr_q;
    logic                                core_start_q;
    logic                                rvalid_q;
    logic [WordW-1:0]                    rdata_q;

    logic [IdxW-1:0]                     idx_c;
    logic                                wr_c, rd_c, busy_c;
    logic                                start_req_c, clr_done_c, intr_en_wr_c;
    logic [WordW-1:0]                    rd_val_c;
    logic                                unused_addr_c;

    assign core_words_c  = core_state_i;
    assign idx_c         = slave_bus.addr[7:2];
    assign unused_addr_c = ^{slave_bus.addr[31:8], slave_bus.addr[1:0]};
    assign wr_c          = slave_bus.req & slave_bus.we;
    assign rd_c          = slave_bus.req & ~slave_bus.we;
    assign busy_c        = (state_q == RUN);

    assign start_req_c  = wr_c && (idx_c == IdxW'(CtrlIdx))   && slave_bus.be[0] && slave_bus.wdata[0];
    assign clr_done_c   = wr_c && (idx_c == IdxW'(StatusIdx)) && slave_bus.be[0] && slave_bus.wdata[1];
    assign intr_en_wr_c = wr_c && (idx_c == IdxW'(IntrEnIdx)) && slave_bus.be[0];

    // Read mux; reserved words fall through to zero.
    always_comb begin
        rd_val_c = '0;
        for (int unsigned w = 0; w < STATE_WORDS; w++) begin
            if (idx_c == IdxW'(w)) rd_val_c = buf_q[w];
        end
        if (idx_c == IdxW'(StatusIdx)) rd_val_c = {30'b0, done_q, busy_c};
        if (idx_c == IdxW'(IntrEnIdx)) rd_val_c = {31'b0, intr_en_q};
    end

    // Completion set is applied last so it wins over a same-cycle clear.
    always_comb begin
        done_d    = done_q;
        intr_en_d = intr_en_q;
        if (clr_done_c)                       done_d = 1'b0;
        if (state_q == IDLE && start_req_c)   done_d = 1'b0;
        if (state_q == RUN  && core_done_i)   done_d = 1'b1;
        if (intr_en_wr_c)                     intr_en_d = slave_bus.wdata[0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            done_q       <= 1'b0;
            intr_en_q    <= 1'b0;
            intr_q       <= 1'b0;
            core_start_q <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_req_c) begin
                        core_start_q <= 1'b1;
                        state_q      <= RUN;
                    end
                    // Buffer is only host-writable while the core is idle.
                    if (wr_c) begin
                        for (int unsigned w = 0; w < STATE_WORDS; w++) begin
                            if (idx_c == IdxW'(w)) begin
                                for (int unsigned b = 0; b < BeW; b++) begin
                                    if (slave_bus.be[b])
                                        buf_q[w][b*ByteW +: ByteW] <= slave_bus.wdata[b*ByteW +: ByteW];
                                end
                            end
                        end
                    end
                end
                RUN: begin
                    if (core_done_i) begin
                        buf_q   <= core_words_c;
                        state_q <= IDLE;
                    end
                end
            endcase
            done_q    <= done_d;
            intr_en_q <= intr_en_d;
            intr_q    <= done_d & intr_en_d;
            rvalid_q  <= slave_bus.req;
            rdata_q   <= rd_c ? rd_val_c : '0;
        end
    end

    assign slave_bus.gnt    = slave_bus.req;
    assign slave_bus.rvalid = rvalid_q;
    assign slave_bus.rdata  = rdata_q;
    assign core_start_o     = core_start_q;
    assign core_state_o     = buf_q;
    assign intr_o           = intr_q;
endmodule

// File: doc/keccak_obi_ctrl.md
# keccak_obi_ctrl

Memory-mapped front end for the Keccak-f[1600] permutation core. It sits on the external-bus slave port at `KECCAK_IDX` (one `ext_slave_req`/`ext_slave_resp` pair) and holds the 1600-bit state in a 50-word register buffer. It launches the permutation core, captures its result, and drives the Keccak interrupt line into `ext_intr_vector[0]`.

## Interface
Parameters:
- STATE_WORDS, 50, number of 32-bit state words; fixed at 50 for Keccak-f[1600].

Ports (decided: one clock; reset asynchronous, active-low):
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- slave_req_i  in  obi_req_t  OBI request from ext_bus (req, we, be, addr, wdata)
- slave_resp_o  out  obi_resp_t  OBI response (gnt, rvalid, rdata)
- core_start_o  out  1  one-cycle start pulse to the permutation core
- core_state_o  out  1600  buffer contents; word i drives bits [32i+31:32i]
- core_done_i  in  1  one-cycle completion pulse from the core
- core_state_i  in  1600  permuted state, valid when core_done_i=1
- intr_o  out  1  level interrupt, equal to done AND intr_en

## Operation
- Decode uses addr[7:2] only (word index W). Higher bits are already decoded by ext_bus.
- W=0..49 DATA[W]: read/write state word. Writes honour be per byte.
- W=50 CTRL: a write with be[0]=1 and wdata[0]=1 requests start. Reads return 0.
- W=51 STATUS: bit0 busy, bit1 done (read-only fields). A write with be[0]=1 and wdata[1]=1 clears done.
- W=52 INTR_EN: bit0 read/write.
- W=53..63 reserved: reads return 0, writes are ignored, and the access is still acknowledged.
- FSM has two states, IDLE and RUN.
  - IDLE + start request: assert core_start_o for exactly one cycle, clear done, set busy, go to RUN.
  - RUN + core_done_i: load all 50 words from core_state_i, set done, clear busy, go to IDLE.
- In RUN:
  - DATA writes are ignored. The access is acknowledged with no effect.
  - DATA reads return the buffer (the input state).
  - A start request is ignored.
- core_done_i in IDLE is ignored.
- The same cycle may carry both core_done_i and a STATUS done-clear write. The set wins and done ends at 1.
- A start write issued while done=1 clears done in the same cycle busy is set.
- intr_o = done & intr_en, driven from registers.

## Timing
- gnt = req, combinational. Every request is accepted in its own cycle; there is no backpressure.
- rvalid is asserted exactly one cycle after each accepted request, for reads and writes alike.
- rdata is registered. For reads it holds the value as of the grant cycle; for writes it is 0.
- Register updates from a write take effect on the grant-cycle clock edge, so a read in the next cycle sees the new value.
- Latency from the CTRL write grant edge:
  - core_start_o is high during cycle +1.
  - busy reads 1 for any read granted from cycle +1 onward.
- core_done_i sampled high at edge E: the buffer, done and intr_o update at E, and busy reads 0 from then on.
- Back-to-back requests on consecutive cycles are supported. The rvalid stream mirrors the gnt stream delayed by one cycle.
- Reset values: buffer all 0, busy 0, done 0, intr_en 0, FSM IDLE, core_start_o 0, intr_o 0, rvalid 0, rdata 0.
- Reset asserted mid-RUN returns to IDLE immediately with all values above. A later core_done_i from the core is ignored.

## Test plan
- Write DATA[0]=0x0000_0001 and DATA[49]=0x8000_0000, then read all 52 registers (W=0..51) -> reads return the written words, 0 elsewhere, STATUS=0; core_state_o[0]=1, core_state_o[1599]=1.
- Byte enables: write 0xAABBCCDD be=4'b0101 to DATA[3], which resets to 0 -> readback 0x00BB00DD.
- Start with INTR_EN=1 and a core model returning the input XOR 1600'h1 after 24 cycles -> core_start_o is high for exactly 1 cycle; STATUS=0x1 while running; then STATUS=0x2, intr_o=1, DATA[0] is bit-flipped. Writing STATUS=0x2 drops intr_o on the next cycle.
- Accesses during RUN:
  - write DATA[5] -> ignored;
  - second CTRL start -> no second core_start_o pulse;
  - read DATA[5] -> returns the pre-start value.
- Same cycle core_done_i and a STATUS clear write -> done=1, intr_o=1 (if enabled).
- Reset asserted 10 cycles into RUN, then core_done_i pulses -> all outputs 0, STATUS=0, the buffer stays 0; back-to-back reads of W=60 on 4 consecutive cycles -> 4 rvalid pulses with rdata=0.
